reaction_game_multi: RTL and testbench

Parametrised multi-player reaction-time game core: after Start, waits a pseudo-random delay, lights LED, and measures in BCD milliseconds how long each player takes to press Stop. It keeps a per-player best score and flags false starts. It sits between the button synchronizers' raw inputs and the four-digit seven-segment controller, and replaces the single-player Start/Stop/BestScore datapath.

---
 rtl/reaction_game_multi_pkg.sv | 21 ++
 rtl/reaction_game_multi_if.sv | 31 +++
 rtl/reaction_game_multi_bcd_counter.sv | 44 ++++
 rtl/reaction_game_multi.sv | 175 +++++++++++++++++
 tb/tb_reaction_game_multi.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/reaction_game_multi_pkg.sv
// Shared types and constants for the multi-player reaction game core.
package reaction_game_multi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_GO   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // All-9s for up to eight BCD digits; users slice off what they need.
  localparam logic [31:0] BCD_MAX = 32'h9999_9999;

  // Fibonacci taps 16,14,13,11 expressed as a bit mask on lfsr[15:0].
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reaction_game_multi_if.sv
// Button inputs and display/status outputs of the reaction game core.
interface reaction_game_multi_if
  import reaction_game_multi_pkg::*;
#(
  parameter int NUM_PLAYERS  = 2,
  parameter int SCORE_DIGITS = 4
);
  localparam int SEL_W = clog2_min1(NUM_PLAYERS);

  logic                      start;
  logic [NUM_PLAYERS-1:0]    stop;
  logic                      show_best;
  logic [SEL_W-1:0]          sel;
  logic [4*SCORE_DIGITS-1:0] score;
  logic [SEL_W-1:0]          winner;
  logic                      win_valid;
  logic                      led;
  logic [NUM_PLAYERS-1:0]    foul;
  logic                      busy;

  modport master (
    output start, stop, show_best, sel,
    input  score, winner, win_valid, led, foul, busy
  );

  modport slave (
    input  start, stop, show_best, sel,
    output score, winner, win_valid, led, foul, busy
  );

endinterface

// File: rtl/reaction_game_multi_bcd_counter.sv
// Multi-digit BCD up-counter with synchronous clear; holds at all-9s.
module bcd_counter
  import reaction_game_multi_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                en,
  output logic [4*DIGITS-1:0] count,
  output logic                all9
);

  logic [4*DIGITS-1:0] count_nxt;
  logic                carry;

  assign all9 = (count == BCD_MAX[4*DIGITS-1:0]);

  always_comb begin
    count_nxt = count;
    carry     = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count[4*i +: 4] == 4'd9) begin
          count_nxt[4*i +: 4] = 4'd0;
        end else begin
          count_nxt[4*i +: 4] = count[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (en && !all9)
      count <= count_nxt;
  end

endmodule

// File: rtl/reaction_game_multi.sv
// Multi-player reaction game: random wait, LED, BCD-ms timing of first Stop,
// per-player best score and false-start flags.
module reaction_game_multi
  import reaction_game_multi_pkg::*;
#(
  parameter int          NUM_PLAYERS      = 2,
  parameter int          TICK_DIV         = 50000,
  parameter int          SCORE_DIGITS     = 4,
  parameter int          MIN_DELAY_MS     = 1000,
  parameter int          DELAY_RANGE_LOG2 = 12,
  parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
  input logic                  clk,
  input logic                  rst,
  reaction_game_multi_if.slave bus
);

  localparam int SEL_W = clog2_min1(NUM_PLAYERS);
  localparam int SW    = 4 * SCORE_DIGITS;
  localparam int PS_W  = $clog2(TICK_DIV);
  localparam int DLY_W = $clog2(MIN_DELAY_MS + (1 << DELAY_RANGE_LOG2) + 1);
  localparam logic [SW-1:0] ALL9 = BCD_MAX[SW-1:0];

  state_t state, state_nxt;

  logic [NUM_PLAYERS:0]   pad, s1, s2, s3, edge_q;
  logic                   start_edge, any_stop;
  logic [NUM_PLAYERS-1:0] stop_edge;
  logic [15:0]            lfsr;
  logic [PS_W-1:0]        presc;
  logic                   tick;
  logic [DLY_W-1:0]       delay;
  logic [SW-1:0]          count, result, score;
  logic                   all9;
  logic [SEL_W-1:0]       win_idx, winner;
  logic                   win_valid;
  logic [NUM_PLAYERS-1:0] foul;
  logic [SW-1:0]          best [NUM_PLAYERS];
  logic                   evt_start, evt_go, evt_foul, evt_win, evt_timeout;
  logic                   led_c, busy_c;

  // Per button: two sync flops, then a registered rising-edge pulse.
  assign pad = {bus.stop, bus.start};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0; s2 <= '0; s3 <= '0; edge_q <= '0;
    end else begin
      s1     <= pad;
      s2     <= s1;
      s3     <= s2;
      edge_q <= s2 & ~s3;
    end
  end

  assign start_edge = edge_q[0];
  assign stop_edge  = edge_q[NUM_PLAYERS:1];
  assign any_stop   = |stop_edge;

  always_comb begin
    win_idx = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--)
      if (stop_edge[i]) win_idx = SEL_W'(i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end

  assign tick = (presc == PS_W'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    evt_start   = 1'b0;
    evt_go      = 1'b0;
    evt_foul    = 1'b0;
    evt_win     = 1'b0;
    evt_timeout = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start_edge) begin
          state_nxt = ST_WAIT;
          evt_start = 1'b1;
        end
      end
      ST_WAIT: begin
        if (any_stop) begin
          state_nxt = ST_DONE;
          evt_foul  = 1'b1;
        end else if (tick && delay <= DLY_W'(1)) begin
          state_nxt = ST_GO;
          evt_go    = 1'b1;
        end
      end
      ST_GO: begin
        // A press on the timeout tick still wins with the pre-increment count.
        if (any_stop) begin
          state_nxt = ST_DONE;
          evt_win   = 1'b1;
        end else if (tick && all9) begin
          state_nxt   = ST_DONE;
          evt_timeout = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    led_c  = (state == ST_GO);
    busy_c = (state == ST_WAIT) || (state == ST_GO);
  end

  bcd_counter #(.DIGITS(SCORE_DIGITS)) u_count (
    .clk   (clk),
    .rst   (rst),
    .clear (evt_go),
    .en    (led_c && tick),
    .count (count),
    .all9  (all9)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc     <= '0;
      delay     <= '0;
      result    <= '0;
      winner    <= '0;
      win_valid <= 1'b0;
      foul      <= '0;
      score     <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) best[i] <= ALL9;
    end else begin
      if (evt_start || evt_go) presc <= '0;
      else if (busy_c)         presc <= tick ? '0 : presc + PS_W'(1);

      if (evt_start)
        delay <= DLY_W'(MIN_DELAY_MS) + DLY_W'(lfsr[DELAY_RANGE_LOG2-1:0]);
      else if (state == ST_WAIT && tick)
        delay <= delay - DLY_W'(1);

      if (evt_start) begin
        foul      <= '0;
        win_valid <= 1'b0;
      end
      if (evt_foul) foul <= stop_edge;

      if (evt_win || evt_timeout) begin
        result    <= count;
        win_valid <= evt_win;
      end
      if (evt_win) begin
        winner <= win_idx;
        if (count < best[win_idx]) best[win_idx] <= count;
      end

      if (!bus.show_best)                     score <= result;
      else if (32'(bus.sel) < NUM_PLAYERS)    score <= best[bus.sel];
      else                                    score <= ALL9;
    end
  end

  assign bus.score     = score;
  assign bus.winner    = winner;
  assign bus.win_valid = win_valid;
  assign bus.led       = led_c;
  assign bus.foul      = foul;
  assign bus.busy      = busy_c;

endmodule

// File: tb/tb_reaction_game_multi.sv
// Directed bench for reaction_game_multi with a 4-cycle ms tick and short delays.
module tb_reaction_game_multi;
  import reaction_game_multi_pkg::*;

  localparam int NP = 2;
  localparam int SD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reaction_game_multi_if #(.NUM_PLAYERS(NP), .SCORE_DIGITS(SD)) bus ();

  reaction_game_multi #(
    .NUM_PLAYERS(NP), .TICK_DIV(4), .SCORE_DIGITS(SD),
    .MIN_DELAY_MS(2), .DELAY_RANGE_LOG2(2), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        show_best;
    logic [0:0]  sel;
    logic [15:0] exp_score;
  } view_t;

  view_t views[8];
  int    n_vec = 0;
  int    n_bad = 0;
  int    n;
  bit    led_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_views(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      bus.show_best = views[i].show_best;
      bus.sel       = views[i].sel;
      repeat (2) @(negedge clk);
      check($sformatf("view%0d", i), 32'(bus.score), 32'(views[i].exp_score));
    end
    bus.show_best = 1'b0;
    bus.sel       = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic press_start();
    bus.start = 1'b1;
    for (int i = 0; i < 20 && !bus.busy; i++) @(negedge clk);
    check("busy_rise", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
  endtask

  task automatic wait_led();
    for (int i = 0; i < 200 && !bus.led; i++) @(negedge clk);
    check("led_rise", 32'(bus.led), 32'd1);
  endtask

  // Pressing d = 4k-2 cycles after LED is first seen lands the edge mid-way
  // through millisecond k, so the expected result is k.
  task automatic press_stop_after(input int d, input logic [1:0] who);
    repeat (d) @(negedge clk);
    bus.stop = who;
    for (int i = 0; i < 20 && bus.busy; i++) @(negedge clk);
    check("busy_fall", 32'(bus.busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic release_stop();
    bus.stop = '0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    bus.start = 1'b0; bus.stop = '0; bus.show_best = 1'b0; bus.sel = '0;
    views[0] = '{1'b1, 1'b1, 16'h0007};
    views[1] = '{1'b1, 1'b0, 16'h9999};
    views[2] = '{1'b0, 1'b0, 16'h0007};
    views[3] = '{1'b1, 1'b1, 16'h0007};
    views[4] = '{1'b1, 1'b0, 16'h0003};
    views[5] = '{1'b0, 1'b0, 16'h0012};
    views[6] = '{1'b1, 1'b1, 16'h9999};
    views[7] = '{1'b1, 1'b0, 16'h9999};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_score", 32'(bus.score), 32'h0);
    check("rst_led", 32'(bus.led), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_winner", 32'(bus.winner), 32'd0);
    check("rst_winvalid", 32'(bus.win_valid), 32'd0);
    check("rst_foul", 32'(bus.foul), 32'd0);

    // Player 1 alone, 7 ms.
    press_start();
    wait_led();
    press_stop_after(26, 2'b10);
    check("a_winner", 32'(bus.winner), 32'd1);
    check("a_winvalid", 32'(bus.win_valid), 32'd1);
    check("a_score", 32'(bus.score), 32'h0007);
    check("a_led", 32'(bus.led), 32'd0);
    release_stop();
    apply_views(0, 2);

    // Both players in the same cycle, 3 ms: lowest index wins.
    press_start();
    wait_led();
    press_stop_after(10, 2'b11);
    check("b_winner", 32'(bus.winner), 32'd0);
    check("b_winvalid", 32'(bus.win_valid), 32'd1);
    check("b_score", 32'(bus.score), 32'h0003);
    release_stop();

    // False start by player 1.
    press_start();
    bus.stop = 2'b10;
    led_seen = 1'b0;
    for (int i = 0; i < 20 && bus.busy; i++) begin
      @(negedge clk);
      if (bus.led) led_seen = 1'b1;
    end
    check("c_busy_fall", 32'(bus.busy), 32'd0);
    check("c_led_never", 32'(led_seen), 32'd0);
    check("c_foul", 32'(bus.foul), 32'h2);
    check("c_winvalid", 32'(bus.win_valid), 32'd0);
    repeat (2) @(negedge clk);
    check("c_score_kept", 32'(bus.score), 32'h0003);
    release_stop();
    check("c_foul_held", 32'(bus.foul), 32'h2);

    // Nobody presses: timeout after 9999 ms plus one tick.
    press_start();
    check("d_foul_clear", 32'(bus.foul), 32'd0);
    wait_led();
    n = 0;
    while (bus.busy && n < 41000) begin
      @(negedge clk);
      n++;
    end
    check("d_timeout_cycles", 32'(n), 32'd40000);
    repeat (2) @(negedge clk);
    check("d_score", 32'(bus.score), 32'h9999);
    check("d_winvalid", 32'(bus.win_valid), 32'd0);
    check("d_winner_kept", 32'(bus.winner), 32'd0);
    check("d_led", 32'(bus.led), 32'd0);

    // Slower second win by player 1 must not replace the 7 ms best.
    press_start();
    wait_led();
    press_stop_after(46, 2'b10);
    check("e_winner", 32'(bus.winner), 32'd1);
    check("e_winvalid", 32'(bus.win_valid), 32'd1);
    check("e_score", 32'(bus.score), 32'h0012);
    release_stop();
    apply_views(3, 5);

    // Reset in the middle of GO.
    press_start();
    wait_led();
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("f_led_async", 32'(bus.led), 32'd0);
    check("f_busy", 32'(bus.busy), 32'd0);
    check("f_score", 32'(bus.score), 32'h0);
    check("f_winvalid", 32'(bus.win_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    apply_views(6, 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
